// File: rtl/ysyx_24100006_icache.sv
// ysyx_24100006_icache
// Direct-mapped, read-only instruction cache between the IFU and an AXI4
// read slave. A hit answers one cycle after the request is accepted. A miss
// refills the whole line with a single INCR burst. fence_i drops every line.
//
// Ports
//   clk_i, reset_i            clock and synchronous active-high reset
//   req_valid_i/req_ready_o   IFU fetch request handshake (ready only in S_IDLE)
//   req_addr_i                fetch PC; bits [1:0] are ignored
//   resp_valid_o/resp_ready_i response handshake; the response holds until taken
//   resp_inst_o, resp_err_o   instruction word and refill error flag
//   fence_i_i                 one-cycle pulse that invalidates all lines
//   axi_ar*_o/axi_arready_i   refill read-address channel (one burst in flight)
//   axi_r*_i/axi_rready_o     refill read-data channel
module ysyx_24100006_icache #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_inst_o,
  output logic        resp_err_o,
  input  logic        fence_i_i,
  output logic [31:0] axi_araddr_o,
  output logic        axi_arvalid_o,
  input  logic        axi_arready_i,
  output logic [7:0]  axi_arlen_o,
  output logic [2:0]  axi_arsize_o,
  input  logic        axi_rvalid_i,
  output logic        axi_rready_o,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i,
  input  logic        axi_rlast_i
);

  localparam int WOFF_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WOFF_W + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL_AR,
    S_REFILL_R,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [31:2]        addr_q, addr_d;
  logic [SETS-1:0]    valid_q, valid_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_inst_q, resp_inst_d;
  logic               resp_err_q, resp_err_d;
  logic               arvalid_q, arvalid_d;
  logic [31:0]        araddr_q, araddr_d;
  logic               rready_q, rready_d;
  logic [WOFF_W-1:0]  beat_q, beat_d;
  logic               err_q, err_d;
  logic               fence_pend_q, fence_pend_d;

  logic [TAG_W-1:0]   tag_mem  [SETS];
  logic [31:0]        data_mem [SETS][LINE_WORDS];

  logic [WOFF_W-1:0]  off;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               r_beat;
  logic               beat_err;
  logic               err_now;
  logic               line_we;
  logic               install;

  // The two low PC bits select a byte inside an instruction word and play no part.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^req_addr_i[1:0];

  assign off    = addr_q[OFF_W-1:2];
  assign idx    = addr_q[OFF_W+IDX_W-1:OFF_W];
  assign tag    = addr_q[31:OFF_W+IDX_W];
  assign hit    = valid_q[idx] && (tag_mem[idx] == tag);
  assign r_beat = axi_rvalid_i && rready_q;

  assign req_ready_o   = (state_q == S_IDLE);
  assign resp_valid_o  = resp_valid_q;
  assign resp_inst_o   = resp_inst_q;
  assign resp_err_o    = resp_err_q;
  assign axi_araddr_o  = araddr_q;
  assign axi_arvalid_o = arvalid_q;
  assign axi_arlen_o   = 8'(LINE_WORDS - 1);
  assign axi_arsize_o  = 3'b010;
  assign axi_rready_o  = rready_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch can be inferred.
    state_d      = state_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    resp_valid_d = resp_valid_q;
    resp_inst_d  = resp_inst_q;
    resp_err_d   = resp_err_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    rready_d     = rready_q;
    beat_d       = beat_q;
    err_d        = err_q;
    fence_pend_d = fence_pend_q;
    line_we      = 1'b0;
    install      = 1'b0;
    beat_err     = 1'b0;
    err_now      = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i[31:2];
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (hit) begin
          resp_inst_d  = data_mem[idx][off];
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          araddr_d     = {tag, idx, {OFF_W{1'b0}}};
          arvalid_d    = 1'b1;
          fence_pend_d = 1'b0;
          state_d      = S_REFILL_AR;
        end
      end

      S_REFILL_AR: begin
        if (axi_arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          beat_d    = '0;
          err_d     = 1'b0;
          state_d   = S_REFILL_R;
        end
      end

      S_REFILL_R: begin
        if (r_beat) begin
          line_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == off) begin
            resp_inst_d = axi_rdata_i;
          end
          // A burst whose rlast does not land on the final word is a
          // protocol error: the line is incomplete or overwritten.
          beat_err = axi_rlast_i != (beat_q == LAST_BEAT);
          err_now  = err_q | (axi_rresp_i != 2'b00) | beat_err;
          err_d    = err_now;
          if (axi_rlast_i) begin
            rready_d     = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = err_now;
            state_d      = S_RESP;
            // A fence landing on the rlast cycle blocks install just like an
            // earlier one recorded in fence_pend_q.
            install      = !err_now && !fence_pend_q && !fence_i_i;
          end
        end
      end

      S_RESP: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // The lookup above already used the pre-fence valid bits; the clear
    // only takes effect at the next edge.
    if (fence_i_i) begin
      valid_d = '0;
      if (state_q == S_REFILL_AR || state_q == S_REFILL_R) begin
        fence_pend_d = 1'b1;
      end
    end else if (install) begin
      valid_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      valid_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_inst_q  <= '0;
      resp_err_q   <= 1'b0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      rready_q     <= 1'b0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      fence_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      resp_valid_q <= resp_valid_d;
      resp_inst_q  <= resp_inst_d;
      resp_err_q   <= resp_err_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      rready_q     <= rready_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      fence_pend_q <= fence_pend_d;
    end
  end

  // NOTE: tag and data arrays have no reset; the valid bits alone decide
  // whether their contents mean anything, which keeps them plain RAMs.
  always_ff @(posedge clk_i) begin
    if (line_we) begin
      data_mem[idx][beat_q] <= axi_rdata_i;
    end
    if (install) begin
      tag_mem[idx] <= tag;
    end
  end

endmodule
